// File: rtl/cic_comp_pkg.sv
// cic_comp_pkg: shared constants, state encoding and sizing helpers for the CIC compensation FIR.
package cic_comp_pkg;
  localparam int DEF_TAPS = 16;
  localparam int DEF_COEF_FRAC = 14;
  typedef enum logic [1:0] {IDLE, MAC, ROUND} state_e;
  function automatic int acc_width(int dw, int cw, int taps);
    return dw + cw + $clog2(taps);
  endfunction
  // Default coefficient array: unity at tap 0, all others zero, i.e. a passthrough filter.
  function automatic int def_coef(int k, int frac);
    return (k == 0) ? (1 << frac) : 0;
  endfunction
endpackage

// File: rtl/cic_comp_mac.sv
// cic_comp_mac: full-precision multiply-accumulate with round-half-up and output saturation.
module cic_comp_mac #(
  parameter int DW = 15,
  parameter int CW = 16,
  parameter int FRAC = 14,
  parameter int AW = 35,
  parameter int OW = 18
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic                 fin_i,
  input  logic signed [DW-1:0] x_i,
  input  logic signed [CW-1:0] c_i,
  output logic                 out_valid_o,
  output logic signed [OW-1:0] out_data_o
);
  localparam logic signed [AW:0] MAXV = (AW+1)'(2 ** (OW - 1) - 1);
  localparam logic signed [AW:0] MINV = (AW+1)'(-(2 ** (OW - 1)));
  logic signed [DW+CW-1:0] prod;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [AW:0] rnd, r;
  logic signed [OW-1:0] sat, data_q, data_d;
  logic valid_q;
  always_comb begin
    prod = x_i * c_i;
    acc_d = clr_i ? '0 : en_i ? acc_q + AW'(prod) : acc_q;
    rnd = {acc_q[AW-1], acc_q} + (AW+1)'(2 ** (FRAC - 1));
    r = rnd >>> FRAC;
    sat = r > MAXV ? OW'(MAXV) : r < MINV ? OW'(MINV) : OW'(r);
    data_d = fin_i ? sat : data_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      data_q <= data_d;
      valid_q <= fin_i;
    end
  end
  assign out_valid_o = valid_q;
  assign out_data_o = data_q;
endmodule

// File: rtl/cic_comp_fir_serial.sv
// cic_comp_fir_serial: single-multiplier CIC droop-compensation FIR, one tap per clock after each input strobe.
module cic_comp_fir_serial
  import cic_comp_pkg::*;
#(
  parameter int DATA_WIDTH = 15,
  parameter int COEF_WIDTH = 16,
  parameter int COEF_FRAC = DEF_COEF_FRAC,
  parameter int TAPS = DEF_TAPS,
  parameter int OUTPUT_WIDTH = 18
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  input  logic signed [DATA_WIDTH-1:0]   in_data,
  input  logic                           coef_we,
  input  logic [$clog2(TAPS)-1:0]        coef_addr,
  input  logic signed [COEF_WIDTH-1:0]   coef_wdata,
  input  logic                           overrun_clr,
  output logic                           out_valid,
  output logic signed [OUTPUT_WIDTH-1:0] out_data,
  output logic                           busy,
  output logic                           overrun
);
  localparam int AB = $clog2(TAPS);
  localparam int AW = acc_width(DATA_WIDTH, COEF_WIDTH, TAPS);
  localparam logic [AB-1:0] K_LAST = AB'(TAPS - 1);
  state_e state_q, state_d;
  logic signed [DATA_WIDTH-1:0] x_q [TAPS];
  logic signed [COEF_WIDTH-1:0] c_q [TAPS];
  logic [AB-1:0] wr_ptr_q, rd_ptr_q, k_q;
  logic overrun_q, overrun_d;
  logic mac_clr, mac_en, mac_fin, busy_w;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = in_valid ? MAC : IDLE;
      MAC:     state_d = (k_q == K_LAST) ? ROUND : MAC;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy_w = state_q != IDLE;
    mac_clr = in_valid && state_q == IDLE;
    mac_en = state_q == MAC;
    mac_fin = state_q == ROUND;
  end
  // A strobe arriving while busy is dropped; a new drop outranks a same-cycle clear.
  assign overrun_d = (in_valid && busy_w) || (overrun_q && !overrun_clr);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
        c_q[i] <= COEF_WIDTH'(def_coef(i, COEF_FRAC));
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      k_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (mac_clr) begin
        x_q[wr_ptr_q] <= in_data;
        rd_ptr_q <= wr_ptr_q;
        wr_ptr_q <= wr_ptr_q + 1'b1;
        k_q <= '0;
      end
      if (mac_en) begin
        rd_ptr_q <= rd_ptr_q - 1'b1;
        k_q <= k_q + 1'b1;
      end
      if (coef_we && !busy_w) c_q[coef_addr] <= coef_wdata;
      overrun_q <= overrun_d;
    end
  end
  cic_comp_mac #(
    .DW(DATA_WIDTH),
    .CW(COEF_WIDTH),
    .FRAC(COEF_FRAC),
    .AW(AW),
    .OW(OUTPUT_WIDTH)
  ) u_mac (
    .clk(clk),
    .reset(reset),
    .clr_i(mac_clr),
    .en_i(mac_en),
    .fin_i(mac_fin),
    .x_i(x_q[rd_ptr_q]),
    .c_i(c_q[k_q]),
    .out_valid_o(out_valid),
    .out_data_o(out_data)
  );
  assign busy = busy_w;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_cic_comp_fir_serial.sv
// tb_cic_comp_fir_serial: directed checks of latency, filtering, rounding, saturation, overrun and reset.
module tb_cic_comp_fir_serial;
  logic clk = 1'b0;
  logic reset, in_valid, coef_we, overrun_clr, out_valid, busy, overrun;
  logic signed [14:0] in_data;
  logic [3:0] coef_addr;
  logic signed [15:0] coef_wdata;
  logic signed [17:0] out_data;
  int n_assert = 0;
  int n_fail = 0;
  int lat;
  int pulses;
  int vin [5] = '{500, 0, 0, 0, 0};
  int vexp [5] = '{0, 0, 0, 500, 0};
  always #5 clk = ~clk;
  cic_comp_fir_serial dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .overrun_clr(overrun_clr), .out_valid(out_valid), .out_data(out_data),
    .busy(busy), .overrun(overrun)
  );
  task automatic chk(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic longint model(longint s);
    longint r = (s + 8192) >>> 14;
    return r > 131071 ? 131071 : r < -131072 ? -131072 : r;
  endfunction
  task automatic send(input logic signed [14:0] v);
    @(negedge clk);
    in_valid = 1'b1;
    in_data = v;
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic wait_out(input int start, output int n);
    n = start;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic run(input logic signed [14:0] v, input string tag, input longint exp);
    send(v);
    wait_out(0, lat);
    chk({tag, "_lat"}, lat, 17);
    chk(tag, out_data, exp);
  endtask
  task automatic wcoef(input int k, input logic signed [15:0] v);
    @(negedge clk);
    coef_we = 1'b1;
    coef_addr = 4'(k);
    coef_wdata = v;
    @(negedge clk);
    coef_we = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_wdata = '0;
    overrun_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1'b0;
    // Default passthrough coefficients, exact latency
    send(1000);
    chk("busy_in_mac", busy, 1);
    wait_out(0, lat);
    chk("latency", lat, 17);
    chk("pass_pos", out_data, 1000);
    @(negedge clk);
    chk("valid_one_cycle", out_valid, 0);
    chk("data_hold", out_data, 1000);
    run(-1000, "pass_neg", -1000);
    // Pure delay of three samples through c[3]
    do_reset();
    wcoef(0, 0);
    wcoef(3, 16384);
    for (int i = 0; i < 5; i++) run(15'(vin[i]), $sformatf("delay3_%0d", i), vexp[i]);
    // Moving average ramp with c[k]=1024
    do_reset();
    for (int k = 0; k < 16; k++) wcoef(k, 1024);
    for (int m = 1; m <= 16; m++) run(1000, $sformatf("ramp_%0d", m), model(longint'(m) * 1024000));
    chk("ramp_final", out_data, 1000);
    // Positive then negative saturation
    for (int k = 0; k < 16; k++) wcoef(k, 16383);
    for (int m = 1; m <= 16; m++)
      run(16383, $sformatf("satp_%0d", m),
          model(longint'(m) * 16383 * 16383 + longint'(16 - m) * 1000 * 16383));
    chk("sat_pos_final", out_data, 131071);
    for (int m = 1; m <= 16; m++)
      run(-16384, $sformatf("satn_%0d", m),
          model(-longint'(m) * 16384 * 16383 + longint'(16 - m) * 16383 * 16383));
    chk("sat_neg_final", out_data, -131072);
    // Overrun: second strobe five clocks after the first is dropped
    do_reset();
    send(1000);
    repeat (4) @(negedge clk);
    in_valid = 1'b1;
    in_data = 5000;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(5, lat);
    chk("ovr_lat", lat, 17);
    chk("ovr_data", out_data, 1000);
    chk("ovr_flag", overrun, 1);
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("ovr_no_extra", pulses, 0);
    wcoef(1, 16384);
    run(0, "ovr_hist_kept", 1000);
    chk("ovr_sticky", overrun, 1);
    @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    chk("ovr_cleared", overrun, 0);
    send(200);
    repeat (2) @(negedge clk);
    in_valid = 1'b1;
    in_data = 7;
    overrun_clr = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    overrun_clr = 1'b0;
    wait_out(3, lat);
    chk("ovr_set_wins", overrun, 1);
    chk("ovr_set_data", out_data, 200);
    // Coefficient writes: ignored while busy, applied first when coincident with a strobe in IDLE
    do_reset();
    send(300);
    coef_we = 1'b1;
    coef_addr = 4'd0;
    coef_wdata = 16'sd0;
    @(negedge clk);
    coef_we = 1'b0;
    wait_out(1, lat);
    chk("busy_we_first", out_data, 300);
    run(400, "busy_we_ignored", 400);
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 600;
    coef_we = 1'b1;
    coef_addr = 4'd0;
    coef_wdata = 16'sd8192;
    @(negedge clk);
    in_valid = 1'b0;
    coef_we = 1'b0;
    wait_out(0, lat);
    chk("idle_we_lands_first", out_data, 300);
    // Reset during MAC abandons the computation and clears history
    send(900);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("midrst_no_valid", pulses, 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_busy", busy, 0);
    for (int k = 0; k < 16; k++) wcoef(k, 16384);
    run(700, "midrst_hist_clear", 700);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
